rr_arbiter8: RTL and testbench

//  Round-robin arbiter sharing one downstream resource (e.g. an encoder/datapath slot) among
//  N requesters. Issues one-hot grant plus binary grant index (8->3 encoded form).

---
 rtl/rr_arbiter_pkg.sv | 26 ++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_arbiter8.sv | 118 +++++++++++
 tb/tb_rr_arbiter8.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter.
// Default build sizes: 8 requesters, 3-bit index, 16-cycle hold limit.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_DEF        = 8;
    localparam int IDX_W_DEF    = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W_DEF    = 5;

    // OR-reduction encoder; it is only ever fed a one-hot or all-zero vector.
    // It is 16 bits wide so that it covers every legal N.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: the first candidate after last_ptr, ascending and wrapping.
// Candidates are req with the bits in excl_mask removed.
import rr_arbiter_pkg::*;

module rr_pick #(
    parameter int N     = N_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_ptr,
    input  logic [N-1:0]     excl_mask,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] probe;

    assign cand = req & ~excl_mask;

    // N is a power of two, so the IDX_W-bit add wraps modulo N for free.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        probe  = '0;
        for (int k = 1; k <= N; k++) begin
            probe = last_ptr + IDX_W'(k);
            if (!found && cand[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: the owner keeps its grant while it requests, and the grant rotates on release.
// Optional hold-time limit with forced release, enabled by defining RR_HOLD_TIMEOUT_EN.
import rr_arbiter_pkg::*;

module rr_arbiter8 #(
    parameter int N     = N_DEF,
    parameter int IDX_W = $clog2(N)
`ifdef RR_HOLD_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // state | meaning
    // IDLE  | no owner, gnt is all-zero
    // BUSY  | the owner is gnt_idx and it holds gnt

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0] search_ptr, winner;
    logic [N-1:0]     excl_mask;
    logic             found, owner_req, expire, rotate;

    assign gnt_idx   = IDX_W'(onehot_to_idx(16'(gnt)));
    assign gnt_valid = |gnt;
    assign owner_req = |(req & gnt);

`ifdef RR_HOLD_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q;

    assign expire = (state_q == BUSY) && owner_req && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // The count is cleared on every new grant, including when the same owner is granted again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= expire;
            if (expire || gnt_d != gnt)
                hold_cnt_q <= '0;
            else if (state_q == BUSY)
                hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // On release the search starts just after the owner, so the owner has the lowest priority.
    assign rotate     = (state_q == BUSY) && (!owner_req || expire);
    assign search_ptr = rotate ? gnt_idx : last_ptr_q;
    assign excl_mask  = rotate ? gnt : '0;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req      (req),
        .last_ptr (search_ptr),
        .excl_mask(excl_mask),
        .winner   (winner),
        .found    (found)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = BUSY;
                    gnt_d   = N'(1) << winner;
                end
            end
            BUSY: begin
                if (rotate) begin
                    last_ptr_d = gnt_idx;
                    if (en && found) begin
                        gnt_d = N'(1) << winner;
                    end else if (en && expire) begin
                        gnt_d = gnt;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt        <= '0;
            last_ptr_q <= IDX_W'(N - 1);
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8 using directed scenarios and a randomized run against an ownership model.
// Timeout checks are enabled when RR_HOLD_TIMEOUT_EN is defined.
module tb_rr_arbiter8;

`ifdef RR_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad = 0;

    // The model tracks who owns the resource, where the search resumes, and how long the owner has held it.
    int m_owner;
    int m_last;
    int m_held;
    bit m_to;

    rr_arbiter8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int from, input int excl);
        for (int k = 1; k <= 8; k++) begin
            int j;
            j = (from + k) % 8;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        logic [2:0] i;
        g = 8'h00;
        i = 3'd0;
        if (m_owner >= 0) begin
            g = 8'(1) << m_owner;
            i = 3'(m_owner);
        end
        return {g, i, (m_owner >= 0), m_to};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_tick();
        int  w;
        bit  forced;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = en ? pick(req, m_last, -1) : -1;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else if (!req[m_owner] || (TO_EN && m_held == MAX_HOLD)) begin
            forced = req[m_owner];
            m_to   = forced;
            m_last = m_owner;
            w = en ? pick(req, m_owner, m_owner) : -1;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end else if (en && forced) begin
                m_held = 1;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b1;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        #1;
        total++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'h0) begin
            bad++;
            $display("FAIL reset_out got=%h want=0", {gnt, gnt_idx, gnt_valid, timeout});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                bad++;
                $display("FAIL idle_hold c=%0d got=%h want=%h", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 8'h01;
        tick();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got gnt=%h idx=%0d want gnt=01 idx=0", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release got gnt=%h want 00", gnt);
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        req = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++) begin
            total++;
            if (gnt_idx !== 3'(g % 8) || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL rotation g=%0d got idx=%0d v=%b want idx=%0d v=1", g, gnt_idx, gnt_valid, g % 8);
            end
            for (int h = 0; h < 2; h++) begin
                tick();
                total++;
                if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                    bad++;
                    $display("FAIL rotation_hold g=%0d got=%h want=%h", g, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
                end
            end
            req[gnt_idx] = 1'b0;
            tick();
            req = 8'hFF;
        end
    endtask

    task automatic test_skip();
        apply_reset();
        req = 8'h04;
        tick();
        req = 8'h84;
        tick();
        total++;
        if (gnt_idx !== 3'd2) begin
            bad++;
            $display("FAIL skip_owner got idx=%0d want 2", gnt_idx);
        end
        req = 8'h80;
        tick();
        total++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
            bad++;
            $display("FAIL skip_wrap got gnt=%h idx=%0d want gnt=80 idx=7", gnt, gnt_idx);
        end
        req = 8'h04;
        tick();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
            bad++;
            $display("FAIL skip_back got gnt=%h idx=%0d want gnt=04 idx=2", gnt, gnt_idx);
        end
    endtask

    task automatic test_en_freeze();
        apply_reset();
        req = 8'h08;
        tick();
        en  = 1'b0;
        req = 8'h10;
        tick();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL freeze_release got gnt=%h want 00", gnt);
        end
        tick();
        total++;
        if (gnt !== 8'h00) begin
            bad++;
            $display("FAIL freeze_hold got gnt=%h want 00", gnt);
        end
        en = 1'b1;
        tick();
        total++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
            bad++;
            $display("FAIL freeze_resume got gnt=%h idx=%0d want gnt=10 idx=4", gnt, gnt_idx);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 8'h30;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'h0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", {gnt, gnt_idx, gnt_valid, timeout});
        end
        model_reset();
        req = 8'hFF;
        #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            bad++;
            $display("FAIL async_restart got gnt=%h idx=%0d want gnt=01 idx=0", gnt, gnt_idx);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            else if (m_owner >= 0 && $urandom_range(0, 5) == 0) req[m_owner] = 1'b0;
            en = ($urandom_range(0, 9) != 0);
            tick();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL random c=%0d req=%h got=%h want=%h", c, req, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
        en = 1'b1;
    endtask

`ifdef RR_HOLD_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        pulses = 0;
        apply_reset();
        req = 8'h03;
        tick();
        for (int c = 0; c < 16; c++) begin
            total++;
            if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_hold c=%0d got idx=%0d v=%b to=%b want idx=0 v=1 to=0", c, gnt_idx, gnt_valid, timeout);
            end
            tick();
        end
        total++;
        if (gnt_idx !== 3'd1 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_force got idx=%0d to=%b want idx=1 to=1", gnt_idx, timeout);
        end
        req = 8'h01;
        tick();
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (timeout === 1'b1) pulses++;
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec() || gnt_idx !== 3'd0) begin
                bad++;
                $display("FAIL to_alone c=%0d got=%h want=%h", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL to_pulses got=%0d want=2", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_skip();
        test_en_freeze();
        test_async_reset();
`ifdef RR_HOLD_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
